// File: rtl/cmos_frame_pkg.sv
// Shared types and default widths for the camera frame gate.
package cmos_frame_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_CW = 24;
  localparam int DEF_LW = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_END     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // One FIFO slot at the default pixel width: end-of-frame flag above the pixel.
  typedef struct packed {
    logic              last;
    logic [DEF_DW-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/cmos_frame_gate_fifo.sv
// Single-clock first-word-fall-through FIFO. A push into a full FIFO is
// dropped and flagged, unless a pop in the same cycle frees the slot.
module stream_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_pop_valid,
  input  logic             i_pop_ready
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_full      = (r_count == DEPTH[AW:0]);
  assign w_pop       = i_pop_ready && (r_count != '0);
  assign w_wr        = i_push && (!w_full || w_pop);
  assign o_full      = w_full;
  assign o_empty     = (r_count == '0);
  assign o_drop      = i_push && w_full && !w_pop && !i_flush;
  assign o_pop_valid = (r_count != '0);
  // Head entry is only meaningful while valid; drive zero otherwise.
  assign o_pop_data  = o_pop_valid ? r_mem[r_rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/cmos_frame_gate.sv
// Gates exactly one VSYNC-aligned camera frame into a ready/valid stream with
// an end-of-frame flag, buffering the non-stallable input in a small FIFO.
module cmos_frame_gate
  import cmos_frame_pkg::*;
#(
  parameter int DW               = DEF_DW,
  parameter int FIFO_AW          = 4,
  parameter int CW               = DEF_CW,
  parameter int LW               = DEF_LW,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          vsync_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  input  logic          cfg_arm,
  input  logic          cfg_continuous,
  input  logic          cfg_abort,
  input  logic [CW-1:0] cfg_frame_pixels,
  output logic [DW-1:0] m_data_o,
  output logic          m_last_o,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          overflow_o,
  output logic          short_frame_o,
  output logic [CW-1:0] stat_pixels_o,
  output logic [LW-1:0] stat_lines_o,
  output logic [15:0]   frame_cnt_o
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_vs_q;
  logic          r_vld_q;
  logic          r_pend_vld;
  logic          r_pend_last;
  logic [DW-1:0] r_pend_data;
  logic [CW-1:0] r_pix_cnt;
  logic [LW-1:0] r_line_cnt;
  logic          r_done;
  logic          r_overflow;
  logic          r_short;
  logic [CW-1:0] r_stat_pixels;
  logic [LW-1:0] r_stat_lines;
  logic [15:0]   r_frame_cnt;

  logic          w_sof;
  logic          w_cfg_nz;
  logic [CW-1:0] w_pix_inc;
  logic          w_cap;
  logic          w_cap_last;
  logic          w_push;
  logic          w_push_last;
  logic          w_end_vs;
  logic          w_frame_done;
  logic          w_clr_flags;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_drop;
  logic [DW:0]   w_pop_data;

  // Line counter holds at all-ones rather than wrapping.
  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_sof     = VSYNC_ACTIVE_LOW ? (r_vs_q & ~vsync_i) : (~r_vs_q & vsync_i);
  assign w_cfg_nz  = |cfg_frame_pixels;
  // The first pixel of a frame counts from zero, since the counter is cleared at sof.
  assign w_pix_inc = ((r_state == ST_CAPTURE) ? r_pix_cnt : '0) + CW'(1);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and per-cycle capture/push decisions; abort overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_cap        = 1'b0;
    w_cap_last   = 1'b0;
    w_push       = 1'b0;
    w_push_last  = 1'b0;
    w_end_vs     = 1'b0;
    w_frame_done = 1'b0;
    w_clr_flags  = 1'b0;
    if (cfg_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_arm) begin
            w_state_nxt = ST_ARMED;
            w_clr_flags = 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_sof) begin
            w_state_nxt = ST_CAPTURE;
            if (valid_i) begin
              w_cap      = 1'b1;
              w_cap_last = w_cfg_nz && (w_pix_inc == cfg_frame_pixels);
              if (w_cap_last) w_state_nxt = ST_END;
            end
          end
        end
        ST_CAPTURE: begin
          if (w_sof) begin
            w_end_vs    = 1'b1;
            w_push      = r_pend_vld;
            w_push_last = 1'b1;
            w_state_nxt = ST_DRAIN;
          end else if (valid_i) begin
            w_cap      = 1'b1;
            w_push     = r_pend_vld;
            w_cap_last = w_cfg_nz && (w_pix_inc == cfg_frame_pixels);
            if (w_cap_last) w_state_nxt = ST_END;
          end
        end
        ST_END: begin
          w_push      = r_pend_vld;
          w_push_last = r_pend_last;
          w_state_nxt = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_fifo_empty) begin
            w_frame_done = 1'b1;
            w_state_nxt  = cfg_continuous ? ST_ARMED : ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Control, counters, sticky flags and frame statistics.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vs_q        <= 1'b0;
      r_vld_q       <= 1'b0;
      r_pend_vld    <= 1'b0;
      r_pend_last   <= 1'b0;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_short       <= 1'b0;
      r_stat_pixels <= '0;
      r_stat_lines  <= '0;
      r_frame_cnt   <= '0;
    end else begin
      r_vs_q  <= vsync_i;
      r_vld_q <= w_cap;
      r_done  <= w_frame_done;
      if (cfg_abort) begin
        r_pend_vld  <= 1'b0;
        r_pend_last <= 1'b0;
      end else begin
        if (w_cap) begin
          r_pend_vld  <= 1'b1;
          r_pend_last <= w_cap_last;
        end else if (w_push) begin
          r_pend_vld  <= 1'b0;
          r_pend_last <= 1'b0;
        end
        if (r_state == ST_ARMED && w_sof) begin
          r_pix_cnt  <= w_cap ? w_pix_inc : '0;
          r_line_cnt <= w_cap_last ? LW'(1) : '0;
        end else if (r_state == ST_CAPTURE) begin
          if (w_cap) r_pix_cnt <= w_pix_inc;
          // The frame-ending pixel closes its line; its falling edge would land in END.
          if ((r_vld_q && !valid_i) || w_cap_last) r_line_cnt <= sat_inc(r_line_cnt);
        end
        if (w_drop)                     r_overflow <= 1'b1;
        else if (w_clr_flags)           r_overflow <= 1'b0;
        if (w_end_vs && w_cfg_nz)       r_short <= 1'b1;
        else if (w_clr_flags)           r_short <= 1'b0;
        if (w_frame_done) begin
          r_stat_pixels <= r_pix_cnt;
          r_stat_lines  <= r_line_cnt;
          r_frame_cnt   <= r_frame_cnt + 16'd1;
        end
      end
    end
  end

  // Pending pixel data; qualified by r_pend_vld so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_cap) r_pend_data <= data_i;
  end

  stream_sync_fifo #(
    .WIDTH (DW + 1),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_flush     (cfg_abort),
    .i_push      (w_push),
    .i_push_data ({w_push_last, r_pend_data}),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_drop      (w_drop),
    .o_pop_data  (w_pop_data),
    .o_pop_valid (m_valid_o),
    .i_pop_ready (m_ready_i)
  );

  assign m_data_o      = w_pop_data[DW-1:0];
  assign m_last_o      = w_pop_data[DW];
  assign busy_o        = (r_state != ST_IDLE);
  assign done_o        = r_done;
  assign overflow_o    = r_overflow;
  assign short_frame_o = r_short;
  assign stat_pixels_o = r_stat_pixels;
  assign stat_lines_o  = r_stat_lines;
  assign frame_cnt_o   = r_frame_cnt;

endmodule

// File: tb/tb_cmos_frame_gate.sv
// Directed bench for cmos_frame_gate: counted, VSYNC-ended, overflow,
// arm alignment, continuous, abort and mid-frame reset scenarios.
`timescale 1ns/1ps
module tb_cmos_frame_gate;

  logic        clk = 1'b0;
  logic        resetn;
  logic        vsync_i, valid_i;
  logic [15:0] data_i;
  logic        cfg_arm, cfg_continuous, cfg_abort;
  logic [23:0] cfg_frame_pixels;
  logic [15:0] m_data_o;
  logic        m_last_o, m_valid_o, m_ready_i;
  logic        busy_o, done_o, overflow_o, short_frame_o;
  logic [23:0] stat_pixels_o;
  logic [11:0] stat_lines_o;
  logic [15:0] frame_cnt_o;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [16:0] beat_q[$];
  int          beat_cyc_q[$];
  int          done_cnt;
  int          done_cyc;

  cmos_frame_gate dut (
    .clk(clk), .resetn(resetn), .vsync_i(vsync_i), .valid_i(valid_i), .data_i(data_i),
    .cfg_arm(cfg_arm), .cfg_continuous(cfg_continuous), .cfg_abort(cfg_abort),
    .cfg_frame_pixels(cfg_frame_pixels), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o), .short_frame_o(short_frame_o), .stat_pixels_o(stat_pixels_o),
    .stat_lines_o(stat_lines_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat and done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn && m_valid_o && m_ready_i) begin
      beat_q.push_back({m_last_o, m_data_o});
      beat_cyc_q.push_back(cyc);
    end
    if (resetn && done_o) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic step(input logic vs, input logic v, input logic [15:0] d);
    vsync_i = vs; valid_i = v; data_i = d;
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    beat_q.delete(); beat_cyc_q.delete(); done_cnt = 0; done_cyc = -1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    step(1'b1, 1'b0, 16'h0);
    clear_mon();
  endtask

  task automatic arm();
    cfg_arm = 1'b1; step(1'b1, 1'b0, 16'h0); cfg_arm = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 300 && done_cnt < target; k++) step(1'b1, 1'b0, 16'h0);
    repeat (3) step(1'b1, 1'b0, 16'h0);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({m_data_o, m_last_o, m_valid_o, busy_o, done_o, overflow_o, short_frame_o,
         stat_pixels_o, stat_lines_o, frame_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h last=%b valid=%b busy=%b done=%b ovf=%b short=%b pix=%0d lines=%0d frames=%0d, required all 0",
               m_data_o, m_last_o, m_valid_o, busy_o, done_o, overflow_o, short_frame_o, stat_pixels_o, stat_lines_o, frame_cnt_o);
    end
  endtask

  task automatic test_counted_frame();
    int nl;
    apply_reset();
    cfg_frame_pixels = 24'd8; m_ready_i = 1'b1;
    arm();
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL cnt_busy_armed: got %b required 1", busy_o); end
    step(1'b0, 1'b0, 16'h0); step(1'b0, 1'b0, 16'h0); step(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 16'(i));
    step(1'b1, 1'b0, 16'h0); step(1'b1, 1'b0, 16'h0);
    for (int i = 5; i <= 8; i++) step(1'b1, 1'b1, 16'(i));
    wait_done(1);
    n_cmp++;
    if (beat_q.size() != 8) begin n_fail++; $display("FAIL cnt_beats: got %0d required 8", beat_q.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (beat_q[i] !== {(i == 7), 16'(i + 1)}) begin
          n_fail++; $display("FAIL cnt_beat%0d: got %h required %h", i, beat_q[i], {(i == 7), 16'(i + 1)});
        end
      end
      n_cmp++;
      if (done_cyc != beat_cyc_q[7] + 2) begin
        n_fail++; $display("FAIL cnt_done_timing: got cycle %0d required %0d", done_cyc, beat_cyc_q[7] + 2);
      end
    end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL cnt_done_pulses: got %0d required 1", done_cnt); end
    n_cmp++; if (stat_pixels_o !== 24'd8) begin n_fail++; $display("FAIL cnt_stat_pixels: got %0d required 8", stat_pixels_o); end
    n_cmp++; if (stat_lines_o !== 12'd2) begin n_fail++; $display("FAIL cnt_stat_lines: got %0d required 2", stat_lines_o); end
    n_cmp++; if (frame_cnt_o !== 16'd1) begin n_fail++; $display("FAIL cnt_frame_cnt: got %0d required 1", frame_cnt_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL cnt_busy_idle: got %b required 0", busy_o); end
    nl = 0;
    foreach (beat_q[i]) if (beat_q[i][16]) nl++;
    n_cmp++; if (nl != 1) begin n_fail++; $display("FAIL cnt_last_count: got %0d required 1", nl); end
  endtask

  task automatic test_vsync_end();
    apply_reset();
    cfg_frame_pixels = 24'd0; m_ready_i = 1'b1;
    arm();
    step(1'b0, 1'b0, 16'h0); step(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 16'(i));
    step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    wait_done(1);
    n_cmp++;
    if (beat_q.size() != 5) begin n_fail++; $display("FAIL vs_beats: got %0d required 5", beat_q.size()); end
    else begin
      n_cmp++; if (beat_q[4] !== 17'h1_0005) begin n_fail++; $display("FAIL vs_last_beat: got %h required 10005", beat_q[4]); end
      n_cmp++; if (beat_q[3] !== 17'h0_0004) begin n_fail++; $display("FAIL vs_beat4: got %h required 00004", beat_q[3]); end
    end
    n_cmp++; if (stat_pixels_o !== 24'd5) begin n_fail++; $display("FAIL vs_stat_pixels: got %0d required 5", stat_pixels_o); end
    n_cmp++; if (stat_lines_o !== 12'd1) begin n_fail++; $display("FAIL vs_stat_lines: got %0d required 1", stat_lines_o); end
    n_cmp++; if (short_frame_o !== 1'b0) begin n_fail++; $display("FAIL vs_short0: got %b required 0", short_frame_o); end
    // Second frame: expected 8 but VSYNC cuts it at 5; first pixel arrives on the sof cycle.
    clear_mon();
    cfg_frame_pixels = 24'd8;
    arm();
    step(1'b0, 1'b1, 16'h0021);
    for (int i = 2; i <= 5; i++) step(1'b0, 1'b1, 16'(32 + i));
    step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    wait_done(1);
    n_cmp++;
    if (beat_q.size() != 5) begin n_fail++; $display("FAIL vs8_beats: got %0d required 5", beat_q.size()); end
    else begin
      n_cmp++; if (beat_q[0] !== 17'h0_0021) begin n_fail++; $display("FAIL vs8_first_beat: got %h required 00021", beat_q[0]); end
      n_cmp++; if (beat_q[4] !== 17'h1_0025) begin n_fail++; $display("FAIL vs8_last_beat: got %h required 10025", beat_q[4]); end
    end
    n_cmp++; if (stat_pixels_o !== 24'd5) begin n_fail++; $display("FAIL vs8_stat_pixels: got %0d required 5", stat_pixels_o); end
    n_cmp++; if (short_frame_o !== 1'b1) begin n_fail++; $display("FAIL vs8_short1: got %b required 1", short_frame_o); end
    n_cmp++; if (frame_cnt_o !== 16'd2) begin n_fail++; $display("FAIL vs8_frame_cnt: got %0d required 2", frame_cnt_o); end
  endtask

  task automatic test_overflow();
    int nl;
    apply_reset();
    cfg_frame_pixels = 24'd20; m_ready_i = 1'b0;
    arm();
    step(1'b0, 1'b0, 16'h0); step(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= 20; i++) step(1'b1, 1'b1, 16'(i));
    repeat (3) step(1'b1, 1'b0, 16'h0);
    n_cmp++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b required 1", overflow_o); end
    n_cmp++; if (m_valid_o !== 1'b1) begin n_fail++; $display("FAIL ovf_valid_held: got %b required 1", m_valid_o); end
    n_cmp++; if (m_data_o !== 16'd1) begin n_fail++; $display("FAIL ovf_head_stable: got %h required 0001", m_data_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL ovf_busy_drain: got %b required 1", busy_o); end
    m_ready_i = 1'b1;
    wait_done(1);
    n_cmp++;
    if (beat_q.size() != 16) begin n_fail++; $display("FAIL ovf_beats: got %0d required 16", beat_q.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (beat_q[i] !== {1'b0, 16'(i + 1)}) begin
          n_fail++; $display("FAIL ovf_beat%0d: got %h required %h", i, beat_q[i], {1'b0, 16'(i + 1)});
        end
      end
    end
    nl = 0;
    foreach (beat_q[i]) if (beat_q[i][16]) nl++;
    n_cmp++; if (nl != 0) begin n_fail++; $display("FAIL ovf_no_last: got %0d required 0", nl); end
    n_cmp++; if (stat_pixels_o !== 24'd20) begin n_fail++; $display("FAIL ovf_stat_pixels: got %0d required 20", stat_pixels_o); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL ovf_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_arm_alignment();
    int nl;
    apply_reset();
    cfg_frame_pixels = 24'd4; m_ready_i = 1'b1;
    step(1'b1, 1'b1, 16'h0050);
    cfg_arm = 1'b1; step(1'b1, 1'b1, 16'h0051); cfg_arm = 1'b0;
    step(1'b1, 1'b1, 16'h0052); step(1'b1, 1'b1, 16'h0053);
    step(1'b1, 1'b0, 16'h0); step(1'b1, 1'b0, 16'h0);
    n_cmp++; if (beat_q.size() != 0) begin n_fail++; $display("FAIL arm_no_early_beats: got %0d required 0", beat_q.size()); end
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL arm_busy: got %b required 1", busy_o); end
    step(1'b0, 1'b0, 16'h0); step(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 16'(96 + i));
    for (int i = 1; i <= 2; i++) step(1'b1, 1'b1, 16'(112 + i));
    wait_done(1);
    n_cmp++;
    if (beat_q.size() != 4) begin n_fail++; $display("FAIL arm_beats: got %0d required 4", beat_q.size()); end
    else begin
      n_cmp++; if (beat_q[0] !== 17'h0_0061) begin n_fail++; $display("FAIL arm_first: got %h required 00061", beat_q[0]); end
      n_cmp++; if (beat_q[3] !== 17'h1_0064) begin n_fail++; $display("FAIL arm_last: got %h required 10064", beat_q[3]); end
    end
    n_cmp++; if (frame_cnt_o !== 16'd1) begin n_fail++; $display("FAIL arm_frame_cnt: got %0d required 1", frame_cnt_o); end

    // Continuous mode: three frames back to back from a single arm.
    apply_reset();
    cfg_frame_pixels = 24'd4; cfg_continuous = 1'b1;
    arm();
    for (int f = 0; f < 3; f++) begin
      if (f == 2) cfg_continuous = 1'b0;
      step(1'b0, 1'b0, 16'h0); step(1'b1, 1'b0, 16'h0);
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 16'(112 + 16 * f + i));
      for (int k = 0; k < 100 && done_cnt < f + 1; k++) step(1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b0, 16'h0);
    end
    repeat (2) step(1'b1, 1'b0, 16'h0);
    n_cmp++; if (frame_cnt_o !== 16'd3) begin n_fail++; $display("FAIL cont_frame_cnt: got %0d required 3", frame_cnt_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL cont_busy: got %b required 0", busy_o); end
    nl = 0;
    foreach (beat_q[i]) if (beat_q[i][16]) nl++;
    n_cmp++; if (nl != 3) begin n_fail++; $display("FAIL cont_last_count: got %0d required 3", nl); end
    n_cmp++;
    if (beat_q.size() != 12) begin n_fail++; $display("FAIL cont_beats: got %0d required 12", beat_q.size()); end
    else begin
      n_cmp++; if (beat_q[11] !== 17'h1_0094) begin n_fail++; $display("FAIL cont_final_beat: got %h required 10094", beat_q[11]); end
    end
  endtask

  task automatic test_abort();
    clear_mon();
    cfg_frame_pixels = 24'd8; m_ready_i = 1'b0;
    arm();
    step(1'b0, 1'b0, 16'h0); step(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 16'(160 + i));
    step(1'b1, 1'b0, 16'h0);
    n_cmp++; if (m_valid_o !== 1'b1) begin n_fail++; $display("FAIL abort_pre_valid: got %b required 1", m_valid_o); end
    cfg_abort = 1'b1; step(1'b1, 1'b0, 16'h0); cfg_abort = 1'b0;
    n_cmp++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b required 0", m_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy_o); end
    m_ready_i = 1'b1;
    repeat (10) step(1'b1, 1'b0, 16'h0);
    n_cmp++; if (beat_q.size() != 0) begin n_fail++; $display("FAIL abort_beats: got %0d required 0", beat_q.size()); end
    n_cmp++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done: got %0d required 0", done_cnt); end
    n_cmp++; if (frame_cnt_o !== 16'd3) begin n_fail++; $display("FAIL abort_frame_cnt: got %0d required 3", frame_cnt_o); end
    n_cmp++; if (stat_pixels_o !== 24'd4) begin n_fail++; $display("FAIL abort_stat_pixels: got %0d required 4", stat_pixels_o); end
  endtask

  task automatic test_reset_midframe();
    cfg_frame_pixels = 24'd8; m_ready_i = 1'b0;
    arm();
    step(1'b0, 1'b0, 16'h0); step(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 16'(176 + i));
    resetn = 1'b0;
    #2;
    n_cmp++;
    if ({m_data_o, m_last_o, m_valid_o, busy_o, done_o, overflow_o, short_frame_o,
         stat_pixels_o, stat_lines_o, frame_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_async_outputs: got valid=%b busy=%b pix=%0d frames=%0d, required all 0",
               m_valid_o, busy_o, stat_pixels_o, frame_cnt_o);
    end
    apply_reset();
    cfg_frame_pixels = 24'd4; m_ready_i = 1'b1;
    arm();
    step(1'b0, 1'b0, 16'h0); step(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 16'(192 + i));
    wait_done(1);
    n_cmp++;
    if (beat_q.size() != 4) begin n_fail++; $display("FAIL rst_beats: got %0d required 4", beat_q.size()); end
    else begin
      n_cmp++; if (beat_q[0] !== 17'h0_00C1) begin n_fail++; $display("FAIL rst_first: got %h required 000C1", beat_q[0]); end
      n_cmp++; if (beat_q[3] !== 17'h1_00C4) begin n_fail++; $display("FAIL rst_last: got %h required 100C4", beat_q[3]); end
    end
    n_cmp++; if (frame_cnt_o !== 16'd1) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d required 1", frame_cnt_o); end
    n_cmp++; if (stat_pixels_o !== 24'd4) begin n_fail++; $display("FAIL rst_stat_pixels: got %0d required 4", stat_pixels_o); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; vsync_i = 1'b1; valid_i = 1'b0; data_i = '0;
    cfg_arm = 1'b0; cfg_continuous = 1'b0; cfg_abort = 1'b0;
    cfg_frame_pixels = '0; m_ready_i = 1'b0;
    done_cnt = 0; done_cyc = -1;
    test_reset();
    test_counted_frame();
    test_vsync_end();
    test_overflow();
    test_arm_alignment();
    test_abort();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
